mem_request_arbiter: RTL and testbench



---
 rtl/mem_request_arbiter.sv | 102 ++++++++++
 tb/tb_mem_request_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_arbiter.sv
// Shares one single-ported RAM between the instruction-fetch port and the data port.
// Data requests win. A streak counter forces a pending fetch through after MAX_DSTREAK data grants.
module mem_request_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int SW          = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        ram_ready,
  input  logic [31:0] ramload,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore
);

  // state  | meaning
  // IDLE   | no access driven; choose the next grant
  // DGRANT | data port owns the RAM until ram_ready or abort
  // IGRANT | fetch port owns the RAM until ram_ready or abort
  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  state_t        state, nextState;
  logic [SW-1:0] streak, nextStreak;
  logic          forceI;

  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= nextState;
      streak <= nextStreak;
    end
  end

  always_comb begin
    nextState  = state;
    nextStreak = streak;
    forceI     = (streak == STREAK_MAX) & iREN;
    iwait      = 1'b1;
    dwait      = 1'b1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    case (state)
      IDLE: begin
        if (forceI)            nextState = IGRANT;
        else if (dREN | dWEN)  nextState = DGRANT;
        else if (iREN)         nextState = IGRANT;
      end
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        // A dropped request abandons the access without touching the streak.
        if (!(dREN | dWEN)) begin
          nextState = IDLE;
        end else begin
          ramWEN = dWEN;
          ramREN = ~dWEN;
          dwait  = ~ram_ready;
          if (ram_ready) begin
            nextState = IDLE;
            if (!iREN)                    nextStreak = '0;
            else if (streak != STREAK_MAX) nextStreak = streak + 1'b1;
          end
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        if (!iREN) begin
          nextState = IDLE;
        end else begin
          ramREN = 1'b1;
          iwait  = ~ram_ready;
          if (ram_ready) begin
            nextState  = IDLE;
            nextStreak = '0;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed-step bench for mem_request_arbiter with immediate assertions at each check point.
module tb_mem_request_arbiter;

  logic        CLK, RST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int nAsserts = 0;
  int nFails   = 0;

  mem_request_arbiter #(.MAX_DSTREAK(4), .SW(3)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ram_ready(ram_ready), .ramload(ramload),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Both waits must never be low together.
  always @(negedge CLK) begin
    nAsserts++;
    assert (!(iwait === 1'b0 && dwait === 1'b0)) else begin
      nFails++;
      $error("FAIL both_waits_low: observed iwait=%b dwait=%b expected not both 0", iwait, dwait);
    end
  end

  logic compl[$];
  int   nCompl;

  initial begin
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ram_ready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    #2;
    check("rst_iwait",    32'(iwait),    32'd1);
    check("rst_dwait",    32'(dwait),    32'd1);
    check("rst_ramREN",   32'(ramREN),   32'd0);
    check("rst_ramWEN",   32'(ramWEN),   32'd0);
    check("rst_ramaddr",  ramaddr,       32'd0);
    check("rst_ramstore", ramstore,      32'd0);
    #21 RST = 1'b0;   // released at t=23, off the clock edge

    // 1: instruction fetch, ram_ready on second grant cycle
    iREN = 1; iaddr = 32'h40;
    #1;
    check("t1_idle_ramREN", 32'(ramREN), 32'd0);
    tick();
    check("t1_g1_ramREN",  32'(ramREN), 32'd1);
    check("t1_g1_ramaddr", ramaddr,     32'h40);
    check("t1_g1_iwait",   32'(iwait),  32'd1);
    tick();
    ram_ready = 1; ramload = 32'h1234_5678;
    #1;
    check("t1_g2_ramREN",  32'(ramREN), 32'd1);
    check("t1_g2_ramaddr", ramaddr,     32'h40);
    check("t1_g2_iwait",   32'(iwait),  32'd0);
    check("t1_g2_dwait",   32'(dwait),  32'd1);
    check("t1_iload",      iload,       32'h1234_5678);
    tick();
    iREN = 0; ram_ready = 0;
    #1;
    check("t1_end_ramREN", 32'(ramREN), 32'd0);
    check("t1_end_iwait",  32'(iwait),  32'd1);

    // 2: simultaneous instr and data write; data first
    iREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD;
    #1;
    check("t2_idle_ramWEN", 32'(ramWEN), 32'd0);
    tick();
    ram_ready = 1;
    #1;
    check("t2_d_ramWEN",   32'(ramWEN), 32'd1);
    check("t2_d_ramREN",   32'(ramREN), 32'd0);
    check("t2_d_ramaddr",  ramaddr,     32'h100);
    check("t2_d_ramstore", ramstore,    32'hDEAD);
    check("t2_d_dwait",    32'(dwait),  32'd0);
    check("t2_d_iwait",    32'(iwait),  32'd1);
    tick();
    dWEN = 0; ram_ready = 0;
    #1;
    check("t2_idle_ramREN",  32'(ramREN), 32'd0);
    check("t2_idle_ramWEN2", 32'(ramWEN), 32'd0);
    tick();
    ram_ready = 1;
    #1;
    check("t2_i_ramREN",  32'(ramREN), 32'd1);
    check("t2_i_ramaddr", ramaddr,     32'h40);
    check("t2_i_iwait",   32'(iwait),  32'd0);
    check("t2_i_dwait",   32'(dwait),  32'd1);
    tick();
    iREN = 0; ram_ready = 0;
    #1;

    // 3: continuous data reads with a pending fetch -> D D D D I repeating
    dREN = 1; iREN = 1; ram_ready = 1; daddr = 32'h200;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (dwait === 1'b0) compl.push_back(1'b0);
      if (iwait === 1'b0) compl.push_back(1'b1);
      if (c == 20) begin
        dREN = 0; iREN = 0; ram_ready = 0;
      end
    end
    nCompl = compl.size();
    check("t3_num_completions", 32'(nCompl), 32'd10);
    for (int k = 0; k < 10; k++) begin
      logic expInstr;
      expInstr = ((k % 5) == 4);
      if (k < nCompl) check($sformatf("t3_completion_%0d", k), 32'(compl[k]), 32'(expInstr));
    end
    #1;

    // 4: data read aborted before ram_ready
    tick();
    dREN = 1; daddr = 32'h280;
    #1;
    tick();
    check("t4_g_ramREN", 32'(ramREN), 32'd1);
    check("t4_g_dwait",  32'(dwait),  32'd1);
    tick();
    dREN = 0;
    #1;
    check("t4_abort_ramREN", 32'(ramREN), 32'd0);
    check("t4_abort_ramWEN", 32'(ramWEN), 32'd0);
    check("t4_abort_dwait",  32'(dwait),  32'd1);
    tick();
    ram_ready = 1;
    #1;
    check("t4_idle_ramREN", 32'(ramREN), 32'd0);
    check("t4_idle_dwait",  32'(dwait),  32'd1);
    ram_ready = 0;

    // 5: build streak=1, then async reset mid-IGRANT
    tick();
    dREN = 1; iREN = 1; iaddr = 32'h80; daddr = 32'h400; ram_ready = 1;
    #1;
    tick();
    check("t5_d_dwait", 32'(dwait), 32'd0);
    tick();
    dREN = 0; ram_ready = 0;
    #1;
    check("t5_streak_one", 32'(dut.streak), 32'd1);
    tick();
    check("t5_ig_ramREN",  32'(ramREN), 32'd1);
    check("t5_ig_ramaddr", ramaddr,     32'h80);
    #2 RST = 1'b1;
    #1;
    check("t5_rst_ramREN", 32'(ramREN),      32'd0);
    check("t5_rst_iwait",  32'(iwait),       32'd1);
    check("t5_rst_streak", 32'(dut.streak),  32'd0);
    #1 RST = 1'b0;
    #1;
    check("t5_rel_ramREN", 32'(ramREN), 32'd0);
    tick();
    ram_ready = 1;
    #1;
    check("t5_ig2_ramREN",  32'(ramREN), 32'd1);
    check("t5_ig2_ramaddr", ramaddr,     32'h80);
    check("t5_ig2_iwait",   32'(iwait),  32'd0);
    tick();
    iREN = 0; ram_ready = 0;
    #1;

    // 6: dREN and dWEN together -> write wins
    dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'hBEEF;
    #1;
    tick();
    check("t6_ramWEN", 32'(ramWEN), 32'd1);
    check("t6_ramREN", 32'(ramREN), 32'd0);
    check("t6_dwait_hold", 32'(dwait), 32'd1);
    tick();
    ram_ready = 1;
    #1;
    check("t6_dwait",    32'(dwait), 32'd0);
    check("t6_ramstore", ramstore,   32'hBEEF);
    tick();
    dREN = 0; dWEN = 0; ram_ready = 0;
    #1;
    check("t6_end_ramWEN", 32'(ramWEN), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
